// File: rtl/gray_ci_pkg.sv
// Shared definitions for the grayscale-to-RGB565 custom instruction.
package gray_ci_pkg;

  localparam int GRAY_W = 8;
  localparam int RGB_W  = 16;

  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_NEXT   = 2'd1;
  localparam logic [1:0] OP_STATUS = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gray_rgb565_expand_if.sv
// Custom-instruction bus between the CPU (master) and a CI block (slave).
interface gray_rgb565_expand_if;

  logic        start;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic [7:0]  iseld;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, valueA, valueB, iseld,
    input  done, result
  );

  modport slave (
    input  start, valueA, valueB, iseld,
    output done, result
  );

endinterface

// File: rtl/gray_to_rgb565.sv
// Combinational 8-bit gray to RGB565 expander: replicate the top gray bits
// into each colour field, truncating (no rounding).
module gray_to_rgb565
  import gray_ci_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [RGB_W-1:0]  rgb
);

  assign rgb = {gray[7:3], gray[7:2], gray[7:3]};

endmodule

// File: rtl/gray_rgb565_expand.sv
// Multi-cycle CI block: LOAD latches four gray pixels and returns the lower
// two as RGB565; NEXT returns the buffered upper two. Fixed 2-cycle latency.
module gray_rgb565_expand
  import gray_ci_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic                 clock,
  input  logic                 reset,
  gray_rgb565_expand_if.slave  bus
);

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] arg_q;
  logic [31:0] buf_q;
  logic        valid_q;
  logic [31:0] result_q;
  logic [31:0] exec_result;
  logic [GRAY_W-1:0] lo_px, hi_px;
  logic [RGB_W-1:0]  lo_rgb, hi_rgb;
  logic        accept;

  // Only operation bits [1:0] of valueB carry meaning.
  logic unused_bits;
  assign unused_bits = ^bus.valueB[31:2];

  assign accept = bus.start && (bus.iseld == customInstructionId) && (state_q == IDLE);

  // State register; reset aborts any in-flight call before done.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update
    // together from pre-edge values.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; starts outside IDLE are ignored, not queued.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture operands only at acceptance; later bus changes have no effect.
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q  <= OP_LOAD;
      arg_q <= '0;
    end else if (accept) begin
      op_q  <= bus.valueB[1:0];
      arg_q <= bus.valueA;
    end
  end

  // LOAD expands the freshly captured low pair; NEXT expands the buffered high pair.
  assign lo_px = (op_q == OP_LOAD) ? arg_q[7:0]  : buf_q[23:16];
  assign hi_px = (op_q == OP_LOAD) ? arg_q[15:8] : buf_q[31:24];

  gray_to_rgb565 u_lo (.gray(lo_px), .rgb(lo_rgb));
  gray_to_rgb565 u_hi (.gray(hi_px), .rgb(hi_rgb));

  // Result selection for the operation being executed.
  always_comb begin
    exec_result = '0;
    unique case (op_q)
      OP_LOAD:   exec_result = {hi_rgb, lo_rgb};
      OP_NEXT:   exec_result = valid_q ? {hi_rgb, lo_rgb} : 32'd0;
      OP_STATUS: exec_result = {31'd0, valid_q};
      OP_RSVD:   exec_result = '0;
      default:   exec_result = '0;
    endcase
  end

  // Buffer, valid flag and result register all update on the edge leaving EXEC.
  always_ff @(posedge clock) begin
    // NOTE: the pixel buffer is cleared on reset so a STATUS/NEXT after reset
    // never exposes stale pixels.
    if (!reset) begin
      buf_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (state_q == EXEC) begin
      result_q <= exec_result;
      if (op_q == OP_LOAD) begin
        buf_q   <= arg_q;
        valid_q <= 1'b1;
      end else if (op_q == OP_NEXT) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Result is zero outside done so several CI blocks can be OR-ed together.
  assign bus.done   = (state_q == DONE);
  assign bus.result = bus.done ? result_q : 32'd0;

endmodule

// File: doc/gray_rgb565_expand.md
# gray_rgb565_expand

Multi-cycle custom-instruction block that converts 8-bit grayscale pixels back into RGB565 for the display path. It is the inverse of the RGB565-to-grayscale instruction and sits on the same CPU custom-instruction bus. Each LOAD call latches four packed gray pixels and returns the first two as RGB565. A following NEXT call returns the remaining two from an internal buffer.

## Interface
- customInstructionId, 8'd0: instruction ID this block responds to.
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse that launches an instruction.
- valueA  input  32  four gray pixels: px0=[7:0], px1=[15:8], px2=[23:16], px3=[31:24].
- valueB  input  32  operation select in [1:0]; bits [31:2] are ignored.
- iseld  input  8  instruction ID currently on the bus.
- done  output  1  one-cycle completion pulse.
- result  output  32  RGB565 pair: lower pixel in [15:0], upper pixel in [31:16]. Zero whenever done=0.

## Operation
- A call is accepted when start=1, iseld==customInstructionId and state is IDLE. In that cycle, valueA and valueB[1:0] are captured.
- Ops selected by valueB[1:0]:
  - 0 LOAD: store all four bytes in the buffer and set valid=1. Result = {rgb(px1), rgb(px0)}.
  - 1 NEXT: if valid=1, result = {rgb(px3), rgb(px2)} and valid clears. If valid=0, result = 0.
  - 2 STATUS: result = {31'd0, valid}. The buffer is unchanged.
  - 3 reserved: result = 0. The buffer is unchanged.
- rgb(g) = {g[7:3], g[7:2], g[7:3]}, i.e. R5 G6 B5 with truncation, no rounding.
- A new LOAD overwrites the buffer even if valid=1. The pending px2/px3 are discarded.
- FSM states:
  - IDLE: accepted start → EXEC.
  - EXEC: compute the result into an output register → DONE.
  - DONE: done=1, result driven → IDLE.
- start with a non-matching iseld is ignored and has no side effects.
- start while in EXEC or DONE is ignored. The CPU stalls until done, so this is a protocol error, not a queued request.
- Only the registered result is driven, gated by done. Outside done, result is 0 so that multiple CI blocks can be OR-ed on the bus.

## Timing
- Reset (reset=0 at a clock edge) forces:
  - state=IDLE, valid=0, buffer=0, done=0, result=0.
  - Reset overrides any in-flight instruction: done is never asserted for an aborted call.
- Latency is fixed at 2 cycles:
  - start accepted at edge N; EXEC during cycle N+1.
  - done=1 and result valid during cycle N+2 only.
- Throughput: one instruction per 3 cycles. A start in the cycle after done (state back in IDLE) is accepted.
- The valid flag and buffer update at the edge leaving EXEC. A STATUS issued right after a NEXT therefore returns 0.
- valueA and valueB are sampled only at acceptance. Later changes have no effect.

## Structure
- Shared package `gray_ci_pkg`:
  - op encoding constants OP_LOAD=2'd0, OP_NEXT=2'd1, OP_STATUS=2'd2, OP_RSVD=2'd3.
  - FSM state enum {IDLE, EXEC, DONE}.
  - pixel width constants GRAY_W=8, RGB_W=16.
- One natural sub-module: `gray_to_rgb565`, the combinational 8→16 bit expander, instantiated twice (lower and upper pixel lanes).
- The FSM, the 32-bit buffer register and the valid flag live in the top module.

## Test plan
- Reset, then LOAD with valueA=0x00FF8040 → done at start+2 with result=0x84104208; STATUS then returns 0x00000001.
- NEXT after that LOAD → result=0x0000FFFF; a following STATUS returns 0x00000000; a second NEXT returns 0x00000000 with done still pulsed.
- start with iseld≠customInstructionId, valueB=0 → done stays 0, result stays 0, STATUS still reports the prior valid.
- LOAD 0x11223344 then LOAD 0xAABBCCDD then NEXT → NEXT returns {rgb(0xAA), rgb(0xBB)} = 0xAD55BDD7; the first load's upper pixels are not visible.
- start held high for 3 consecutive cycles → exactly one done pulse; the next accepted start is the one seen in IDLE.
- LOAD accepted, then reset=0 during EXEC → no done, result=0, STATUS after reset returns 0.
